// File: rtl/accumulate_unit.sv
// accumulate_unit: streaming 16-bit block accumulator with sticky carry flag and carry-event count.
// Optional build macro ACC_SATURATE_EN clamps Result to 16'hFFFF on carry instead of wrapping.
module accumulate_unit #(
    parameter int COUNT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] operand1,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] Result,
    output logic        Cout,
    output logic [7:0]  carry_cnt
);

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    localparam logic [7:0] LAST_BEAT = 8'(COUNT - 1);

    state_t      state_q, state_d;
    logic [15:0] result_q, result_d;
    logic        cout_q, cout_d;
    logic [7:0]  carry_cnt_q, carry_cnt_d;
    logic [7:0]  beat_q, beat_d;
    logic [16:0] sum17;

    assign sum17 = {1'b0, result_q} + {1'b0, operand1};

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        cout_d      = cout_q;
        carry_cnt_d = carry_cnt_q;
        beat_d      = beat_q;

        // clr wins over both an accept and a handoff in the same cycle
        if (clr) begin
            state_d     = ACCUM;
            result_d    = 16'h0000;
            cout_d      = 1'b0;
            carry_cnt_d = 8'h00;
            beat_d      = 8'h00;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (in_valid) begin
`ifdef ACC_SATURATE_EN
                        result_d = sum17[16] ? 16'hFFFF : sum17[15:0];
`else
                        result_d = sum17[15:0];
`endif
                        if (sum17[16]) begin
                            cout_d      = 1'b1;
                            carry_cnt_d = carry_cnt_q + 8'd1;
                        end
                        if (beat_q == LAST_BEAT) begin
                            beat_d  = 8'h00;
                            state_d = DONE;
                        end else begin
                            beat_d = beat_q + 8'd1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d     = ACCUM;
                        result_d    = 16'h0000;
                        cout_d      = 1'b0;
                        carry_cnt_d = 8'h00;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            result_q    <= 16'h0000;
            cout_q      <= 1'b0;
            carry_cnt_q <= 8'h00;
            beat_q      <= 8'h00;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            cout_q      <= cout_d;
            carry_cnt_q <= carry_cnt_d;
            beat_q      <= beat_d;
        end
    end

    // handshake outputs decode the state register only
    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign Result    = result_q;
    assign Cout      = cout_q;
    assign carry_cnt = carry_cnt_q;

endmodule

// File: tb/tb_accumulate_unit.sv
// tb_accumulate_unit: randomized and directed stimulus for accumulate_unit, checked through a
// result scoreboard against a block-level arithmetic model (honours ACC_SATURATE_EN).
module tb_accumulate_unit;

    localparam int COUNT = 4;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] operand1;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] Result;
    logic        Cout;
    logic [7:0]  carry_cnt;

    int errors = 0;
    int checks = 0;

    // words accepted so far in the current block, and pending block results {result, cout, count}
    logic [15:0] blk_words[$];
    logic [24:0] sb[$];
    bit          m_done = 1'b0;

    accumulate_unit #(.COUNT(COUNT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .operand1  (operand1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Result    (Result),
        .Cout      (Cout),
        .carry_cnt (carry_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // expected {result, cout, carry count} for the words accepted so far in a block
    function automatic logic [24:0] block_eval();
        logic [15:0] r;
        int unsigned n;
`ifdef ACC_SATURATE_EN
        int unsigned acc;
        acc = 0;
        n = 0;
        foreach (blk_words[i]) begin
            acc = acc + blk_words[i];
            if (acc > 65535) begin
                acc = 65535;
                n++;
            end
        end
        r = acc[15:0];
`else
        int unsigned total;
        total = 0;
        foreach (blk_words[i]) total = total + blk_words[i];
        r = total[15:0];
        n = total / 65536;
`endif
        return {r, (n != 0), n[7:0]};
    endfunction

    // reference model: tracks handshake state, running value and completed blocks
    always @(negedge clk) begin
        logic [24:0] e;
        if (rst_n) begin
            check_output("in_ready", int'(in_ready), int'(!m_done));
            check_output("out_valid", int'(out_valid), int'(m_done));
            if (!m_done) begin
                e = block_eval();
                check_output("running_result", int'(Result), int'(e[24:9]));
                check_output("running_cout", int'(Cout), int'(e[8]));
                check_output("running_carry_cnt", int'(carry_cnt), int'(e[7:0]));
            end
            if (clr) begin
                blk_words.delete();
                if (m_done && sb.size() > 0) void'(sb.pop_back());
                m_done = 1'b0;
            end else if (!m_done && in_valid) begin
                blk_words.push_back(operand1);
                if (blk_words.size() == COUNT) begin
                    sb.push_back(block_eval());
                    blk_words.delete();
                    m_done = 1'b1;
                end
            end else if (m_done && out_ready) begin
                m_done = 1'b0;
            end
        end
    end

    // monitor: compares each handed-off block result against the scoreboard
    always @(negedge clk) begin
        logic [24:0] e;
        if (rst_n && out_valid && out_ready && !clr) begin
            if (sb.size() == 0) begin
                check_output("unexpected_result", 1, 0);
            end else begin
                e = sb.pop_front();
                check_output("block_result", int'(Result), int'(e[24:9]));
                check_output("block_cout", int'(Cout), int'(e[8]));
                check_output("block_carry_cnt", int'(carry_cnt), int'(e[7:0]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        blk_words.delete();
        sb.delete();
        m_done = 1'b0;
    endtask

    task automatic apply_stimulus(input bit v, input logic [15:0] w, input bit ordy, input bit c);
        in_valid  = v;
        operand1  = w;
        out_ready = ordy;
        clr       = c;
        step();
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        clr = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        operand1 = 16'h0000;
        repeat (3) step();
        rst_n = 1'b1;
        check_output("reset_result", int'(Result), 0);
        check_output("reset_cout", int'(Cout), 0);
        check_output("reset_carry_cnt", int'(carry_cnt), 0);
        check_output("reset_out_valid", int'(out_valid), 0);
        check_output("reset_in_ready", int'(in_ready), 1);

        // wrap / saturate: four 0x4000 words, then backpressure with in_valid held high
        repeat (COUNT) apply_stimulus(1'b1, 16'h4000, 1'b0, 1'b0);
`ifdef ACC_SATURATE_EN
        check_output("wrap_result", int'(Result), 16'hFFFF);
`else
        check_output("wrap_result", int'(Result), 16'h0000);
`endif
        check_output("wrap_cout", int'(Cout), 1);
        check_output("wrap_carry_cnt", int'(carry_cnt), 1);
        check_output("wrap_out_valid", int'(out_valid), 1);
        repeat (5) apply_stimulus(1'b1, 16'h1234, 1'b0, 1'b0);
        apply_stimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        check_output("handoff_in_ready", int'(in_ready), 1);
        check_output("handoff_result", int'(Result), 0);

        // stall gaps with a carry
        apply_stimulus(1'b1, 16'hFFFF, 1'b0, 1'b0);
        apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b0);
        apply_stimulus(1'b1, 16'h0001, 1'b0, 1'b0);
        apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b0);
        apply_stimulus(1'b1, 16'h0001, 1'b0, 1'b0);
        apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b0);
        apply_stimulus(1'b1, 16'h0001, 1'b0, 1'b0);
        apply_stimulus(1'b0, 16'h0000, 1'b1, 1'b0);

        // clr together with out_ready while DONE drops the result
        repeat (COUNT) apply_stimulus(1'b1, 16'h0101, 1'b0, 1'b0);
        apply_stimulus(1'b0, 16'h0000, 1'b1, 1'b1);
        check_output("clr_done_out_valid", int'(out_valid), 0);
        check_output("clr_done_result", int'(Result), 0);

        // clr coincident with an accept leaves Result at zero
        apply_stimulus(1'b1, 16'h0050, 1'b0, 1'b0);
        apply_stimulus(1'b1, 16'h0070, 1'b0, 1'b1);
        check_output("clr_accept_result", int'(Result), 0);

        // asynchronous reset in the middle of a block
        apply_stimulus(1'b1, 16'h0010, 1'b0, 1'b0);
        apply_stimulus(1'b1, 16'h0010, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_output("async_reset_result", int'(Result), 0);
        check_output("async_reset_carry_cnt", int'(carry_cnt), 0);
        check_output("async_reset_out_valid", int'(out_valid), 0);
        model_reset();
        step();
        rst_n = 1'b1;
        step();
        check_output("post_reset_in_ready", int'(in_ready), 1);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [15:0] w;
            w = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(16'h8000, 16'hFFFF))
                                             : 16'($urandom_range(0, 16'hFFFF));
            apply_stimulus(($urandom_range(0, 3) != 0), w, ($urandom_range(0, 2) != 0),
                           ($urandom_range(0, 39) == 0));
        end

        repeat (3) apply_stimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        check_output("scoreboard_drain", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
